// File: rtl/riscv_writeback_unit.sv
// rtl/riscv_writeback_unit.sv - RV64 writeback stage: load wait/extract and registered register-bank write port
module riscv_writeback_unit #(
    parameter int XLEN         = 64,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic            mem_reg_write,
    input  logic            mem_to_reg,
    input  logic [4:0]      mem_rd,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    output logic            rf_write_en,
    output logic [4:0]      rf_write_addr,
    output logic [XLEN-1:0] rf_write_data,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            load_error,
    output logic            load_timeout
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
    localparam int CW = $clog2(LOAD_TIMEOUT + 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_funct3, ld_off;
    logic            ld_wr;
    logic            wr_en_next, err_next, to_next;
    logic [4:0]      wr_addr_next;
    logic [XLEN-1:0] wr_data_next, shifted, extracted;
    logic            illegal;
    logic [2:0]      off;

    assign mem_ready = (state == IDLE);
    assign off       = mem_alu_result[2:0];

    assign illegal = (mem_funct3 == 3'b111)
                  || (mem_funct3[1:0] == 2'b01 && off[0])
                  || (mem_funct3[1:0] == 2'b10 && off[1:0] != 2'b00)
                  || (mem_funct3[1:0] == 2'b11 && off != 3'b000);

    // Bring the addressed byte lane down to bit 0, then size and extend
    assign shifted = load_data >> {ld_off, 3'b000};

    always_comb begin
        extracted = '0;
        case (ld_funct3)
            3'b000:  extracted = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  extracted = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  extracted = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b011:  extracted = shifted;
            3'b100:  extracted = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  extracted = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  extracted = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: extracted = '0;
        endcase
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        wr_en_next   = 1'b0;
        wr_addr_next = rf_write_addr;
        wr_data_next = rf_write_data;
        err_next     = 1'b0;
        to_next      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (!mem_to_reg) begin
                        wr_en_next = mem_reg_write && (mem_rd != 5'd0);
                        if (wr_en_next) begin
                            wr_addr_next = mem_rd;
                            wr_data_next = mem_alu_result;
                        end
                    end else if (illegal) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = WAIT_LOAD;
                        cnt_next   = '0;
                    end
                end
            end
            WAIT_LOAD: begin
                // Returned data takes priority over an expiring timeout
                if (load_valid) begin
                    wr_en_next = ld_wr && (ld_rd != 5'd0);
                    if (wr_en_next) begin
                        wr_addr_next = ld_rd;
                        wr_data_next = extracted;
                    end
                    state_next = IDLE;
                end else if (cnt == CW'(LOAD_TIMEOUT - 1)) begin
                    to_next    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ld_rd         <= '0;
            ld_funct3     <= '0;
            ld_off        <= '0;
            ld_wr         <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            load_error    <= 1'b0;
            load_timeout  <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            rf_write_en   <= wr_en_next;
            rf_write_addr <= wr_addr_next;
            rf_write_data <= wr_data_next;
            load_error    <= err_next;
            load_timeout  <= to_next;
            if (state == IDLE && mem_valid && mem_to_reg) begin
                ld_rd     <= mem_rd;
                ld_funct3 <= mem_funct3;
                ld_off    <= off;
                ld_wr     <= mem_reg_write;
            end
        end
    end

    assign fwd_valid = rf_write_en;
    assign fwd_rd    = rf_write_addr;
    assign fwd_data  = rf_write_data;
endmodule

// File: tb/tb_riscv_writeback_unit.sv
// tb/tb_riscv_writeback_unit.sv - directed and randomized checks of riscv_writeback_unit against a behavioural model
module tb_riscv_writeback_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, mem_reg_write, mem_to_reg;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_alu_result;
    logic        load_valid;
    logic [63:0] load_data;
    logic        rf_write_en, fwd_valid, load_error, load_timeout;
    logic [4:0]  rf_write_addr, fwd_rd;
    logic [63:0] rf_write_data, fwd_data;

    int total = 0;
    int bad   = 0;

    riscv_writeback_unit #(.XLEN(64), .LOAD_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg),
        .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .load_valid(load_valid), .load_data(load_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_error(load_error), .load_timeout(load_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input bit en, input logic [4:0] rd, input logic [63:0] d);
        chk1({tag, ".en"}, rf_write_en, en);
        chk1({tag, ".fwd_valid"}, fwd_valid, en);
        if (en) begin
            chk64({tag, ".addr"}, 64'(rf_write_addr), 64'(rd));
            chk64({tag, ".data"}, rf_write_data, d);
            chk64({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(rd));
            chk64({tag, ".fwd_data"}, fwd_data, d);
        end
    endtask

    // Model: access size is 2**funct3[1:0] bytes; the offset must be a multiple of it
    function automatic bit ref_legal(input logic [2:0] f3, input logic [2:0] off);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return (f3 != 3'b111) && ((int'(off) % nbytes) == 0);
    endfunction

    function automatic logic [63:0] ref_val(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] d);
        int nbytes;
        logic [63:0] mask, v;
        nbytes = 1 << f3[1:0];
        mask = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        v = (d >> (8 * int'(off))) & mask;
        if (!f3[2] && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_alu(input logic [4:0] rd, input logic [63:0] v, input bit regw);
        mem_valid = 1'b1; mem_to_reg = 1'b0; mem_reg_write = regw;
        mem_rd = rd; mem_funct3 = 3'($urandom); mem_alu_result = v;
        load_valid = 1'($urandom); load_data = {$urandom, $urandom};
        chk1("alu.ready", mem_ready, 1'b1);
        step();
        mem_valid = 1'b0; load_valid = 1'b0; mem_alu_result = {$urandom, $urandom};
        chk_write("alu", regw && rd != 0, rd, v);
        step();
        chk_write("alu.after", 1'b0, rd, v);
    endtask

    // d = wait cycle (1-based) on which load_valid is raised; d > 15 means never
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] data, input int d, input bit regw,
                           input bit use_want, input logic [63:0] want);
        logic [63:0] exp;
        mem_valid = 1'b1; mem_to_reg = 1'b1; mem_reg_write = regw;
        mem_rd = rd; mem_funct3 = f3; mem_alu_result = addr;
        chk1("ld.ready_accept", mem_ready, 1'b1);
        step();
        mem_valid = 1'b0;
        if (!ref_legal(f3, addr[2:0])) begin
            chk1("ld.error", load_error, 1'b1);
            chk_write("ld.err_nowrite", 1'b0, rd, 64'd0);
            chk1("ld.err_ready", mem_ready, 1'b1);
            step();
            chk1("ld.error_clear", load_error, 1'b0);
            return;
        end
        chk1("ld.no_error", load_error, 1'b0);
        exp = use_want ? want : ref_val(f3, addr[2:0], data);
        for (int k = 1; k <= 15 && k <= d; k++) begin
            chk1("ld.wait_ready", mem_ready, 1'b0);
            chk1("ld.wait_en", rf_write_en, 1'b0);
            chk1("ld.wait_timeout", load_timeout, 1'b0);
            load_valid = (k == d);
            load_data  = (k == d) ? data : {$urandom, $urandom};
            step();
        end
        load_valid = 1'b0;
        if (d <= 15) begin
            chk_write("ld.write", regw && rd != 0, rd, exp);
            chk1("ld.no_timeout", load_timeout, 1'b0);
        end else begin
            chk1("ld.timeout", load_timeout, 1'b1);
            chk_write("ld.timeout_nowrite", 1'b0, rd, exp);
        end
        chk1("ld.ready_back", mem_ready, 1'b1);
        step();
        chk1("ld.timeout_clear", load_timeout, 1'b0);
        chk1("ld.en_clear", rf_write_en, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_reg_write = 1'b0; mem_to_reg = 1'b0;
        mem_rd = '0; mem_funct3 = '0; mem_alu_result = '0; load_valid = 1'b0; load_data = '0;
        step(); step();
        chk_write("reset", 1'b0, 5'd0, 64'd0);
        chk64("reset.addr", 64'(rf_write_addr), 64'd0);
        chk64("reset.data", rf_write_data, 64'd0);
        chk64("reset.fwd_rd", 64'(fwd_rd), 64'd0);
        chk64("reset.fwd_data", fwd_data, 64'd0);
        chk1("reset.error", load_error, 1'b0);
        chk1("reset.timeout", load_timeout, 1'b0);
        chk1("reset.ready", mem_ready, 1'b1);
        rst = 1'b0;

        do_alu(5'd5, 64'h1234, 1'b1);

        // Back-to-back ALU accepts write every cycle
        mem_valid = 1'b1; mem_to_reg = 1'b0; mem_reg_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            mem_rd = 5'(i + 10); mem_alu_result = 64'(i * 111);
            step();
            chk_write("b2b", 1'b1, 5'(i + 10), 64'(i * 111));
        end
        mem_valid = 1'b0;
        step();
        chk_write("b2b.after", 1'b0, 5'd0, 64'd0);

        do_load(5'd7, 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 4, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(5'd8, 3'b110, 64'h2004, 64'hF000_0001_0000_0000, 2, 1'b1, 1'b1, 64'h0000_0000_F000_0001);
        do_load(5'd9, 3'b101, 64'h2001, 64'h0, 1, 1'b1, 1'b0, 64'h0);
        do_load(5'd10, 3'b011, 64'h3000, 64'hDEAD_BEEF_0123_4567, 16, 1'b1, 1'b0, 64'h0);
        do_load(5'd11, 3'b011, 64'h3000, 64'hDEAD_BEEF_0123_4567, 15, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567);
        do_alu(5'd0, 64'hABCD, 1'b1);
        do_load(5'd12, 3'b010, 64'h4000, 64'h1234_5678_9ABC_DEF0, 5, 1'b0, 1'b0, 64'h0);

        // Reset on the second wait cycle, then a late load_valid
        mem_valid = 1'b1; mem_to_reg = 1'b1; mem_reg_write = 1'b1;
        mem_rd = 5'd13; mem_funct3 = 3'b011; mem_alu_result = 64'h5000;
        step();
        mem_valid = 1'b0;
        step();
        chk1("rst.wait_ready", mem_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("rst.ready", mem_ready, 1'b1);
        chk1("rst.en", rf_write_en, 1'b0);
        chk1("rst.timeout", load_timeout, 1'b0);
        load_valid = 1'b1; load_data = 64'h55;
        step();
        load_valid = 1'b0;
        chk1("rst.late_valid", rf_write_en, 1'b0);
        chk1("rst.ready_after", mem_ready, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_alu(5'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
            else
                do_load(5'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                        int'($urandom_range(1, 17)), 1'($urandom_range(0, 3) != 0), 1'b0, 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
